// File: rtl/sll_seq_pkg.sv
// rtl/sll_seq_pkg.sv - shared types and default widths for the sequential shift-left unit
package sll_seq_pkg;

    localparam int SLL_N     = 8;
    localparam int SLL_AMT_N = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/sll_seq.sv
// rtl/sll_seq.sv - multi-cycle logical left shifter, one bit per enabled clock, sticky overflow
module sll_seq
    import sll_seq_pkg::*;
#(
    parameter int N     = SLL_N,
    parameter int AMT_N = SLL_AMT_N
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic [N-1:0]     d,
    input  logic [AMT_N-1:0] amt,
    output logic             busy,
    output logic             done,
    output logic [N-1:0]     out,
    output logic             ovf
);

    state_t           r_state;
    state_t           w_next;
    logic [N-1:0]     r_sh;
    logic [AMT_N-1:0] r_cnt;
    logic             r_ovf_acc;
    logic [N-1:0]     r_out;
    logic             r_ovf;

    logic             w_accept;
    logic [N-1:0]     w_sh_next;
    logic             w_ovf_next;
    logic             w_last;

    assign w_accept   = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_sh_next  = {r_sh[N-2:0], 1'b0};
    assign w_ovf_next = r_ovf_acc | r_sh[N-1];
    assign w_last     = (r_cnt == AMT_N'(1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else if (en) begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_next = (amt == '0) ? DONE : SHIFT;
                end else begin
                    w_next = IDLE;
                end
            end
            SHIFT: begin
                if (w_last) begin
                    w_next = DONE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // The result registers only move on the edge that enters DONE, so out/ovf stay stable otherwise.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sh      <= '0;
            r_cnt     <= '0;
            r_ovf_acc <= 1'b0;
            r_out     <= '0;
            r_ovf     <= 1'b0;
        end else if (en) begin
            if (w_accept) begin
                r_sh      <= d;
                r_cnt     <= amt;
                r_ovf_acc <= 1'b0;
                if (amt == '0) begin
                    r_out <= d;
                    r_ovf <= 1'b0;
                end
            end else if (r_state == SHIFT) begin
                r_sh      <= w_sh_next;
                r_cnt     <= r_cnt - AMT_N'(1);
                r_ovf_acc <= w_ovf_next;
                if (w_last) begin
                    r_out <= w_sh_next;
                    r_ovf <= w_ovf_next;
                end
            end
        end
    end

    always_comb begin
        busy = (r_state == SHIFT);
        done = (r_state == DONE);
        out  = r_out;
        ovf  = r_ovf;
    end

endmodule

// File: tb/tb_sll_seq.sv
// tb/tb_sll_seq.sv - scoreboard bench for sll_seq with a shift-by-multiply reference model
module tb_sll_seq;

    typedef struct {
        logic [7:0] out;
        logic       ovf;
        int         done_idx;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       en;
    logic       start;
    logic [7:0] d;
    logic [2:0] amt;
    logic       busy;
    logic       done;
    logic [7:0] out;
    logic       ovf;

    int   n_cmp;
    int   n_bad;
    exp_t exp_q[$];
    int   en_count;
    int   last_comp;
    bit   rst_seen;

    sll_seq dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .start (start),
        .d     (d),
        .amt   (amt),
        .busy  (busy),
        .done  (done),
        .out   (out),
        .ovf   (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Result of a left shift: multiply into a 16-bit value; the low byte is the result,
    // anything left in the high byte was pushed out past the MSB.
    function automatic exp_t model(input logic [7:0] dv, input logic [2:0] av, input int idx);
        exp_t     e;
        int       wide;
        wide       = int'(dv) * (1 << av);
        e.out      = wide[7:0];
        e.ovf      = (wide[15:8] != 8'h00);
        e.done_idx = idx + int'(av);
        return e;
    endfunction

    task automatic step(input logic s, input logic [7:0] dv, input logic [2:0] av,
                        input logic e, input logic r);
        exp_t x;
        start = s;
        d     = dv;
        amt   = av;
        en    = e;
        rst   = r;
        @(posedge clk);
        if (!r) begin
            last_comp = -100;
            exp_q.delete();
            rst_seen  = 1'b1;
        end else if (e) begin
            en_count++;
            if (s && (en_count > last_comp)) begin
                x         = model(dv, av, en_count);
                last_comp = x.done_idx;
                exp_q.push_back(x);
            end
        end
        #1;
        chk("busy", 32'(busy), 32'(en_count < last_comp));
        chk("done", 32'(done), 32'(en_count == last_comp));
        if (!r) begin
            chk("rst_out", 32'(out), 32'h0);
            chk("rst_ovf", 32'(ovf), 32'h0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 3'd0, 1'b1, 1'b1);
    endtask

    // Monitor: consumes one expected entry per done presentation and watches out for stray changes.
    initial begin
        int         seen_idx;
        logic [7:0] prev_out;
        logic       prev_ovf;
        bit         fresh;
        exp_t       x;
        seen_idx = -1;
        prev_out = 8'h00;
        prev_ovf = 1'b0;
        forever begin
            @(negedge clk);
            fresh = done && (en_count != seen_idx);
            if (fresh) begin
                seen_idx = en_count;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got done=1, expected no pending op at %0t", $time);
                end else begin
                    x = exp_q.pop_front();
                    chk("out", 32'(out), 32'(x.out));
                    chk("ovf", 32'(ovf), 32'(x.ovf));
                    chk("latency", 32'(en_count), 32'(x.done_idx));
                end
            end else if (rst_seen) begin
                rst_seen = 1'b0;
            end else if (rst === 1'b1) begin
                chk("out_stable", 32'({ovf, out}), 32'({prev_ovf, prev_out}));
            end
            prev_out = out;
            prev_ovf = ovf;
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish, expected finish before 2000000");
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        en_count  = 0;
        last_comp = -100;
        rst_seen  = 1'b0;

        // reset held with start asserted
        step(1'b1, 8'hFF, 3'd3, 1'b1, 1'b0);
        step(1'b1, 8'hFF, 3'd3, 1'b1, 1'b0);
        idle(2);

        // basic, overflow, zero-amount
        step(1'b1, 8'h03, 3'd3, 1'b1, 1'b1);
        idle(5);
        step(1'b1, 8'hC1, 3'd2, 1'b1, 1'b1);
        idle(4);
        step(1'b1, 8'hA5, 3'd0, 1'b1, 1'b1);
        idle(3);

        // stall mid-shift
        step(1'b1, 8'hFF, 3'd7, 1'b1, 1'b1);
        idle(2);
        step(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
        idle(8);

        // ignored start during SHIFT, then back-to-back start in the DONE cycle
        step(1'b1, 8'h03, 3'd2, 1'b1, 1'b1);
        step(1'b1, 8'h01, 3'd2, 1'b1, 1'b1);
        step(1'b0, 8'h00, 3'd0, 1'b1, 1'b1);
        step(1'b1, 8'h01, 3'd1, 1'b1, 1'b1);
        idle(4);

        // stall while DONE is held
        step(1'b1, 8'h11, 3'd1, 1'b1, 1'b1);
        step(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
        idle(3);

        // reset mid-op: operation discarded, no done follows
        step(1'b1, 8'h0F, 3'd5, 1'b1, 1'b1);
        idle(2);
        step(1'b0, 8'h00, 3'd0, 1'b1, 1'b0);
        idle(8);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), 3'($urandom),
                 1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 59) != 0));
        end
        idle(12);

        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sll_seq.md
# sll_seq

Sequential shift-left-logical unit: the left-going counterpart of the catalog's shift-right element. It accepts an operand and shift amount on a start pulse, then shifts one bit position per enabled clock. It reports completion with a one-cycle done pulse and a sticky overflow flag. It sits in the catalog next to the shift-right element as a low-area, multi-cycle shifter for datapaths that can tolerate amount-dependent latency.

## Interface
- n, 8, operand/result width
- amt_n, 3, shift-amount width (max shift 2^amt_n − 1)

- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-low reset
- en  input  1  clock enable; low freezes all state (stall)
- start  input  1  request; sampled only when en=1 and FSM in IDLE or DONE
- d  input  n  operand, captured on accepted start
- amt  input  amt_n  shift amount, captured on accepted start
- busy  output  1  high while in SHIFT
- done  output  1  one-cycle pulse: result valid
- out  output  n  result register, holds last result
- ovf  output  1  1 if any 1-bit was shifted out of MSB in last operation

## Operation
- Reset: rst low at a rising edge → state IDLE, out=0, ovf=0, busy=0, done=0, internal shift reg and counter cleared. Reset has priority over en and start.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE/DONE + en + start: load sh←d, cnt←amt, ovf_acc←0. Next state SHIFT if amt≠0, else DONE.
  - IDLE/DONE, no accepted start: DONE→IDLE, IDLE stays.
  - SHIFT + en: ovf_acc←ovf_acc | sh[n−1]; sh←{sh[n−2:0],1'b0}; cnt←cnt−1. When cnt==1, next state DONE.
  - Entering DONE: out←final sh, ovf←final ovf_acc (for amt=0: out←d, ovf←0).
- start during SHIFT is ignored; there is no queueing.
- Zero fill only. amt ≥ n yields out=0 and still takes amt shift cycles.
- busy = (state==SHIFT); done = (state==DONE). Both are registered state decodes.
- out and ovf change only on entry to DONE or on reset. They are stable in every other cycle.

## Timing
- Start accepted at edge E0. The result is written at edge E0+amt for amt≥1, or at E0 for amt=0.
- done is high for exactly the one cycle following the write edge, provided en is high on the next edge. While en=0, DONE and done=1 persist.
- Each en=0 cycle during SHIFT extends latency by one cycle.
- Back-to-back: start in the DONE cycle is accepted. There is no idle bubble.
- Reset mid-SHIFT: the next cycle shows busy=0, done=0, out=0, ovf=0. The operation is discarded.

## Structure
- Package sll_seq_pkg: state_t enum {IDLE, SHIFT, DONE} (2-bit encoding).
- Single module. The counter and shift register are inline; no sub-module is needed.

## Test plan
- Reset: hold rst=0 for 2 cycles with start=1 → out=8'h00, busy=0, done=0, ovf=0.
- Basic shift: d=8'h03, amt=3, start for 1 cycle → busy for 3 cycles, then done=1, out=8'h18, ovf=0.
- Overflow: d=8'hC1, amt=2 → out=8'h04, ovf=1. Also amt=0, d=8'hA5 → done in the cycle after E0, out=8'hA5, ovf=0, busy never high.
- Stall: d=8'hFF, amt=7, en=0 for 2 cycles mid-SHIFT → done arrives 9 edges after E0, out=8'h80, ovf=1, out unchanged until then.
- Ignored start and back-to-back: start with d=8'h01, amt=2 during SHIFT → ignored, out=8'h0C from the first op (d=8'h03, amt=2). Start in the DONE cycle with d=8'h01, amt=1 → out=8'h02 after 1 shift.
- Reset mid-op: rst=0 during SHIFT of d=8'h0F, amt=5 → next cycle busy=0, out=8'h00; no done pulse follows.
